// File: rtl/rv_isa_pkg.sv
// RV32I immediate-format codes and opcodes shared by the
// decode sign-extension stage and the immediate encoder.
package rv_isa_pkg;

   localparam logic [2:0] FMT_I  = 3'b000;
   localparam logic [2:0] FMT_S  = 3'b001;
   localparam logic [2:0] FMT_B  = 3'b010;
   localparam logic [2:0] FMT_U  = 3'b011;
   localparam logic [2:0] FMT_J  = 3'b100;
   localparam logic [2:0] FMT_LI = 3'b101;

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LI_HI,
      ST_LI_LO
   } li_state_e;

   function automatic logic fits_s12(input logic [31:0] v);
      return (&v[31:11]) | ~(|v[31:11]);
   endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/beat handshake bundle of the immediate encoder.
// master is the requester/consumer side, slave the encoder.
interface imm_encoder_if;

   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_format;
   logic [31:0] in_imm;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic        out_last;

   modport master (
      output in_valid, in_format, in_imm, in_instr, out_ready,
      input  in_ready, out_valid, out_instr, out_err, out_last
   );

   modport slave (
      input  in_valid, in_format, in_imm, in_instr, out_ready,
      output in_ready, out_valid, out_instr, out_err, out_last
   );

endinterface

// File: rtl/imm_scatter.sv
// Scatters an immediate into the I/S/B/U/J fields of a template
// word and flags values the format cannot represent.
module imm_scatter
   import rv_isa_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [31:0] imm,
   input  logic [31:0] tmpl,
   output logic [31:0] instr,
   output logic        err
);

   logic eq11;
   logic eq12;
   logic eq20;

   assign eq11 = fits_s12(imm);
   assign eq12 = (&imm[31:12]) | ~(|imm[31:12]);
   assign eq20 = (&imm[31:20]) | ~(|imm[31:20]);

   always_comb begin
      instr = tmpl;
      err   = 1'b0;
      unique case (1'b1)
         fmt == FMT_I: begin
            instr[31:20] = imm[11:0];
            err          = ~eq11;
         end
         fmt == FMT_S: begin
            instr[31:25] = imm[11:5];
            instr[11:7]  = imm[4:0];
            err          = ~eq11;
         end
         fmt == FMT_B: begin
            instr[31]    = imm[12];
            instr[30:25] = imm[10:5];
            instr[11:8]  = imm[4:1];
            instr[7]     = imm[11];
            err          = ~eq12 | imm[0];
         end
         fmt == FMT_U: begin
            instr[31:12] = imm[31:12];
            err          = |imm[11:0];
         end
         fmt == FMT_J: begin
            instr[31]    = imm[20];
            instr[30:21] = imm[10:1];
            instr[20]    = imm[11];
            instr[19:12] = imm[19:12];
            err          = ~eq20 | imm[0];
         end
         // LI is expanded by the caller; pass the template through
         fmt == FMT_LI: begin
            instr = tmpl;
            err   = 1'b0;
         end
         default: begin
            instr = tmpl;
            err   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: registered output beat, valid/ready on both
// sides, and a small FSM that splits LI into LUI + ADDI.
module imm_encoder
   import rv_isa_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   imm_encoder_if.slave  bus
);

   li_state_e   state, state_n;
   logic        valid_q, valid_n;
   logic [31:0] instr_q, instr_n;
   logic        err_q, err_n;
   logic        last_q, last_n;
   logic [4:0]  rd_q;
   logic [11:0] lo_q;

   logic [31:0] sc_instr;
   logic        sc_err;
   logic        accept;
   logic [4:0]  rd;
   logic [19:0] hi;
   logic        is_li;

   imm_scatter u_scatter (
      .fmt   (bus.in_format),
      .imm   (bus.in_imm),
      .tmpl  (bus.in_instr),
      .instr (sc_instr),
      .err   (sc_err)
   );

   assign bus.in_ready = ~rst & (state == ST_IDLE)
                       & (~valid_q | bus.out_ready);
   assign accept = bus.in_valid & bus.in_ready;
   assign rd     = bus.in_instr[11:7];
   assign is_li  = bus.in_format == FMT_LI;
   // rounding: ADDI sign-extends lo, so bump hi when imm[11] is set
   assign hi     = bus.in_imm[31:12] + {19'd0, bus.in_imm[11]};

   always_comb begin
      state_n = state;
      valid_n = valid_q;
      instr_n = instr_q;
      err_n   = err_q;
      last_n  = last_q;
      if (valid_q && bus.out_ready) valid_n = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               valid_n = 1'b1;
               if (!is_li) begin
                  instr_n = sc_instr;
                  err_n   = sc_err;
                  last_n  = 1'b1;
               end else if (fits_s12(bus.in_imm)) begin
                  instr_n = {bus.in_imm[11:0], 5'd0, 3'b000,
                             rd, OPC_OPIMM};
                  err_n   = 1'b0;
                  last_n  = 1'b1;
               end else begin
                  instr_n = {hi, rd, OPC_LUI};
                  err_n   = 1'b0;
                  last_n  = 1'b0;
                  state_n = ST_LI_HI;
               end
            end
         end
         ST_LI_HI: begin
            if (bus.out_ready) begin
               valid_n = 1'b1;
               instr_n = {lo_q, rd_q, 3'b000, rd_q, OPC_OPIMM};
               err_n   = 1'b0;
               last_n  = 1'b1;
               state_n = ST_LI_LO;
            end
         end
         ST_LI_LO: begin
            if (bus.out_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         valid_q <= 1'b0;
         instr_q <= 32'd0;
         err_q   <= 1'b0;
         last_q  <= 1'b0;
         rd_q    <= 5'd0;
         lo_q    <= 12'd0;
      end else begin
         state   <= state_n;
         valid_q <= valid_n;
         instr_q <= instr_n;
         err_q   <= err_n;
         last_q  <= last_n;
         if (accept) begin
            rd_q <= rd;
            lo_q <= bus.in_imm[11:0];
         end
      end
   end

   assign bus.out_valid = valid_q;
   assign bus.out_instr = instr_q;
   assign bus.out_err   = err_q;
   assign bus.out_last  = last_q;

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the core's immediate sign-extension stage: scatters a 32-bit immediate into the immediate fields of a template RV32I instruction word for formats I/S/B/U/J.
- Flags immediates that cannot be represented in the chosen format.
- Adds a pseudo-format LI that expands a 32-bit constant into a LUI+ADDI pair, or a single ADDI when the constant fits.
- Used by the debug program loader and by self-test stimulus generators; valid/ready on both sides, registered output.

Parameters:
- none; RV32 fixed, XLEN=32

Ports:
- clk        input   1   clock, rising edge
- rst        input   1   synchronous reset, active high
- in_valid   input   1   request valid
- in_ready   output  1   request accepted when in_valid && in_ready
- in_format  input   3   000 I, 001 S, 010 B, 011 U, 100 J, 101 LI; 110/111 illegal
- in_imm     input   32  immediate value, full signed/absolute value, not pre-shifted
- in_instr   input   32  template instruction; its immediate bit positions are ignored; for LI only [11:7] (rd) is used
- out_valid  output  1   output beat valid
- out_ready  input   1   downstream accepts beat
- out_instr  output  32  encoded instruction
- out_err    output  1   immediate not representable, or illegal format; qualifies this beat
- out_last   output  1   final beat of the request (always 1 except LUI beat of LI)

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_instr=0, out_err=0, out_last=0, FSM -> IDLE. Any pending LI second beat is dropped.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational, and 0 during reset cycles.
- Latency: request accepted at edge N -> beat visible (out_valid=1) after edge N, i.e. 1 cycle. Back-to-back throughput: 1 request/cycle for non-LI formats.
- Output hold: while out_valid && !out_ready, out_instr/out_err/out_last are held stable.
- Field placement; non-immediate template bits are copied unchanged:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
- Range rules; violation sets out_err=1, but the encoding is still produced from truncated bits:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
- Illegal format: out_instr=in_instr unchanged, out_err=1, out_last=1.
- LI, with lo = sign-extended imm[11:0] and hi = (imm + 32'h800) >> 12, modulo 2^32:
  - If imm fits 12-bit signed: single beat ADDI rd,x0,lo, i.e. {lo[11:0],5'd0,3'b000,rd,7'b0010011}, out_last=1.
  - Otherwise two beats:
    - Beat 1: LUI rd,hi[19:0], i.e. {hi[19:0],rd,7'b0110111}, out_last=0.
    - Beat 2: ADDI rd,rd,lo, i.e. {lo[11:0],rd,3'b000,rd,7'b0010011}, out_last=1.
  - If lo=0: beat 2 is still emitted (ADDI rd,rd,0); no skipping.
  - LI never sets out_err.
- FSM:
  - IDLE --accept LI needing two beats--> LI_HI
  - LI_HI (beat 1 valid) --out_ready--> LI_LO (beat 2 loaded the same edge)
  - LI_LO --out_ready--> IDLE
  - rd and lo are captured in registers on accept.
  - in_ready=0 in LI_HI and LI_LO.
- Simultaneous events: out_ready and a new accept on the same edge replace the beat with no bubble. rst has priority over everything.

Decomposition:
- Shared package rv_isa_pkg:
  - format codes FMT_I..FMT_J and FMT_LI (3-bit, same codes as the decoder's sign-extension stage)
  - opcode constants OPC_LUI=7'b0110111, OPC_OPIMM=7'b0010011
- One natural combinational sub-module, imm_scatter:
  - inputs: format, imm, template
  - outputs: instruction, range error
- Top level holds the handshake, output register and LI FSM.

Test Plan:
- I, imm=32'hFFFFFFFF, template 32'h00000013 -> one beat: out_instr=32'hFFF00013, out_err=0, out_last=1.
- S, imm=32'h000007FC, template 32'h00002023 -> 32'h7E002E23. B, imm=-4 (32'hFFFFFFFC), template 32'h00000063 -> 32'hFE000EE3.
- Errors:
  - I, imm=32'h00000800 -> out_instr=32'h80000013, out_err=1.
  - J, imm=3 -> out_err=1.
  - format 3'b111 -> out_instr=template, out_err=1.
- LI, imm=32'h12345FFF, template 32'h00000280 (rd=x5):
  - beat 1 32'h123462B7, last=0; beat 2 32'hFFF28293, last=1.
  - in_ready low until beat 2 is accepted.
  - LI imm=32'hFFFFF800 -> single beat 32'h80000293 (ADDI x5,x0,-2048).
- Backpressure: hold out_ready=0 for 3 cycles during an LI beat 1 -> out_instr stable, in_ready=0. Then stream 4 I-format requests with out_ready=1 -> one beat per cycle.
- Assert rst in LI_HI -> next cycle out_valid=0, in_ready=1, and no stale beat 2 appears afterward.
